// File: rtl/filtro_pkg.sv
// Shared definitions for the time-multiplexed biquad filter bank: FSM encoding,
// tap indices and the round/saturate helper used by the shared MAC.
package filtro_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;

  localparam int unsigned NTAPS = 5;

  // Helper works at a fixed maximum width so any legal Width/Presicion fits.
  localparam int ACC_MAX = 128;
  localparam int W_MAX   = 64;

  typedef struct packed {
    logic             satura;
    logic [W_MAX-1:0] valor;
  } res_t;

  function automatic int ancho_dir(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Round half-up by Presicion bits, then clamp to a signed w-bit range.
  function automatic res_t redondea_satura(input logic signed [ACC_MAX-1:0] acc,
                                           input int w, input int prec);
    logic signed [ACC_MAX-1:0] suma;
    logic signed [ACC_MAX-1:0] desp;
    logic signed [ACC_MAX-1:0] vmax;
    logic signed [ACC_MAX-1:0] vmin;
    res_t r;
    suma = acc + (ACC_MAX'(1) <<< (prec - 1));
    desp = suma >>> prec;
    vmax = (ACC_MAX'(1) <<< (w - 1)) - ACC_MAX'(1);
    vmin = -(ACC_MAX'(1) <<< (w - 1));
    r.satura = 1'b0;
    if (desp > vmax) begin
      r.valor  = vmax[W_MAX-1:0];
      r.satura = 1'b1;
    end else if (desp < vmin) begin
      r.valor  = vmin[W_MAX-1:0];
      r.satura = 1'b1;
    end else begin
      r.valor  = desp[W_MAX-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/banco_coef.sv
// Coefficient RAM: one synchronous write port, one combinational read port
// driven by the FSM counters. Out-of-range writes are discarded.
module banco_coef
  import filtro_pkg::*;
#(
  parameter int Width = 22,
  parameter int Depth = 30,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic             wr_ok;

  assign wr_ok = we && ({1'b0, waddr} < DEPTH_L);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < unsigned'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/filtro_banco_mux.sv
// Bands x Stages direct-form-I biquad bank sharing one MAC; one tap per cycle,
// one STORE cycle per biquad, all band outputs published together in DONE.
module filtro_banco_mux
  import filtro_pkg::*;
#(
  parameter int Width     = 22,
  parameter int Presicion = 14,
  parameter int Bands     = 3,
  parameter int Stages    = 2,
  localparam int AW       = ancho_dir(Bands * Stages * NTAPS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   uk_valid,
  input  logic [Width-1:0]       uk,
  output logic                   busy,
  output logic [Bands*Width-1:0] yk,
  output logic                   yk_valid,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic [Width-1:0]       coef_data,
  output logic                   sat,
  output logic                   overrun
);

  localparam int NBQ  = Bands * Stages;
  localparam int BW   = (Bands > 1) ? $clog2(Bands) : 1;
  localparam int SW   = (Stages > 1) ? $clog2(Stages) : 1;
  localparam int QW   = (NBQ > 1) ? $clog2(NBQ) : 1;
  localparam int ACCW = 2 * Width + 3;

  localparam logic [BW-1:0] ULT_BANDA = BW'(Bands - 1);
  localparam logic [SW-1:0] ULT_ETAPA = SW'(Stages - 1);

  logic [1:0]              estado_q, estado_d;
  logic [2:0]              tap_q;
  logic [BW-1:0]           band_q;
  logic [SW-1:0]           stage_q;
  logic [QW-1:0]           bq_q;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [Width-1:0] uk_q;
  logic signed [Width-1:0] x_q;
  logic signed [Width-1:0] x1_q [NBQ];
  logic signed [Width-1:0] x2_q [NBQ];
  logic signed [Width-1:0] y1_q [NBQ];
  logic signed [Width-1:0] y2_q [NBQ];
  logic signed [Width-1:0] sal_q [Bands];
  logic [Bands*Width-1:0]  yk_q;
  logic                    yk_valid_q;
  logic                    sat_q;
  logic                    overrun_q;

  logic                      acepta;
  logic                      coef_wr;
  logic                      ultima_etapa;
  logic                      ultima_banda;
  logic [AW-1:0]             coef_raddr;
  logic signed [Width-1:0]   coef_rd;
  logic signed [Width-1:0]   operando;
  logic signed [2*Width-1:0] producto;
  logic signed [ACC_MAX-1:0] acc_ext;
  logic signed [Width-1:0]   y_red;
  logic                      sat_red;

  // busy covers the yk_valid cycle too, so coefficient writes stay locked out there.
  assign busy     = (estado_q != ST_IDLE) | yk_valid_q;
  assign acepta   = (estado_q == ST_IDLE) & uk_valid & enable;
  assign coef_wr  = coef_we & ~busy;

  assign ultima_etapa = (stage_q == ULT_ETAPA);
  assign ultima_banda = (band_q == ULT_BANDA);

  assign coef_raddr = AW'(bq_q) * AW'(NTAPS) + AW'(tap_q);

  banco_coef #(
    .Width (Width),
    .Depth (NBQ * NTAPS),
    .AW    (AW)
  ) u_coef (
    .clock (clock),
    .reset (reset),
    .we    (coef_wr),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (coef_raddr),
    .rdata (coef_rd)
  );

  always_comb begin
    operando = '0;
    case (tap_q)
      B0:      operando = x_q;
      B1:      operando = x1_q[bq_q];
      B2:      operando = x2_q[bq_q];
      A1:      operando = y1_q[bq_q];
      A2:      operando = y2_q[bq_q];
      default: operando = '0;
    endcase
  end

  assign producto = coef_rd * operando;

  always_comb begin
    acc_d = acc_q + {{3{producto[2*Width-1]}}, producto};
    if (tap_q == B0) begin
      acc_d = {{3{producto[2*Width-1]}}, producto};
    end
  end

  assign acc_ext = {{(ACC_MAX - ACCW){acc_q[ACCW-1]}}, acc_q};

  always_comb begin
    y_red   = Width'(redondea_satura(acc_ext, Width, Presicion));
    sat_red = 1'(redondea_satura(acc_ext, Width, Presicion) >> W_MAX);
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE:  if (acepta) estado_d = ST_MAC;
      ST_MAC:   if (tap_q == A2) estado_d = ST_STORE;
      ST_STORE: estado_d = (ultima_etapa && ultima_banda) ? ST_DONE : ST_MAC;
      ST_DONE:  estado_d = ST_IDLE;
      default:  estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= ST_IDLE;
      tap_q      <= B0;
      band_q     <= '0;
      stage_q    <= '0;
      bq_q       <= '0;
      acc_q      <= '0;
      uk_q       <= '0;
      x_q        <= '0;
      yk_q       <= '0;
      yk_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
      for (int unsigned i = 0; i < unsigned'(NBQ); i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      for (int unsigned b = 0; b < unsigned'(Bands); b++) begin
        sal_q[b] <= '0;
      end
    end else begin
      estado_q   <= estado_d;
      yk_valid_q <= 1'b0;
      if (uk_valid && (estado_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (estado_q)
        ST_IDLE: begin
          if (acepta) begin
            uk_q    <= uk;
            x_q     <= uk;
            tap_q   <= B0;
            band_q  <= '0;
            stage_q <= '0;
            bq_q    <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          tap_q <= (tap_q == A2) ? B0 : tap_q + 3'd1;
        end
        ST_STORE: begin
          x2_q[bq_q] <= x1_q[bq_q];
          x1_q[bq_q] <= x_q;
          y2_q[bq_q] <= y1_q[bq_q];
          y1_q[bq_q] <= y_red;
          sat_q      <= sat_q | sat_red;
          bq_q       <= bq_q + QW'(1);
          // The next band restarts its cascade from the latched input sample.
          if (ultima_etapa) begin
            sal_q[band_q] <= y_red;
            x_q           <= uk_q;
            stage_q       <= '0;
            band_q        <= band_q + BW'(1);
          end else begin
            x_q     <= y_red;
            stage_q <= stage_q + SW'(1);
          end
        end
        ST_DONE: begin
          for (int unsigned b = 0; b < unsigned'(Bands); b++) begin
            yk_q[b*Width +: Width] <= sal_q[b];
          end
          yk_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign yk       = yk_q;
  assign yk_valid = yk_valid_q;
  assign sat      = sat_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_filtro_banco_mux.sv
// Directed bench for filtro_banco_mux: expected band vectors are queued when a
// sample is launched and compared when yk_valid appears.
module tb_filtro_banco_mux;

  localparam int W  = 22;
  localparam int NB = 3;
  localparam int AW = 5;
  localparam int VW = NB * W;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          uk_valid = 1'b0;
  logic [W-1:0]  uk = '0;
  logic          busy;
  logic [VW-1:0] yk;
  logic          yk_valid;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [W-1:0]  coef_data = '0;
  logic          sat;
  logic          overrun;

  int tests = 0;
  int fails = 0;
  logic [VW-1:0] exp_q [$];

  filtro_banco_mux #(
    .Width     (22),
    .Presicion (14),
    .Bands     (3),
    .Stages    (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .uk_valid  (uk_valid),
    .uk        (uk),
    .busy      (busy),
    .yk        (yk),
    .yk_valid  (yk_valid),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .sat       (sat),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    uk_valid = 1'b0;
    coef_we = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    coef_addr = AW'(a);
    coef_data = d;
    coef_we = 1'b1;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic passthru_all();
    for (int q = 0; q < 6; q++) wr(q * 5, 22'h004000);
  endtask

  task automatic lanzar(input logic [W-1:0] u);
    uk = u;
    uk_valid = 1'b1;
    tick();
    uk_valid = 1'b0;
  endtask

  // Called with 'ya' cycles already elapsed since the accepting edge.
  task automatic recoger(input string tag, input int ya);
    int c;
    logic [VW-1:0] e;
    c = ya;
    while (yk_valid !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    chk({tag, "_lat"}, VW'(c), VW'(37));
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_yk"}, yk, e);
    chk({tag, "_busy_at_valid"}, VW'(busy), VW'(1));
    tick();
    chk({tag, "_valid_pulse"}, VW'(yk_valid), VW'(0));
    chk({tag, "_busy_after"}, VW'(busy), VW'(0));
  endtask

  initial begin
    int extra;

    // Reset state and zero-coefficient sample
    do_reset();
    chk("rst_yk", yk, '0);
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_valid", VW'(yk_valid), VW'(0));
    chk("rst_sat", VW'(sat), VW'(0));
    chk("rst_ovr", VW'(overrun), VW'(0));
    exp_q.push_back('0);
    lanzar(22'h001234);
    chk("zero_busy_rise", VW'(busy), VW'(1));
    recoger("zero", 0);

    // enable low: no acceptance
    enable = 1'b0;
    lanzar(22'h000111);
    chk("en_off_busy", VW'(busy), VW'(0));
    tick();
    chk("en_off_busy2", VW'(busy), VW'(0));
    chk("en_off_ovr", VW'(overrun), VW'(0));
    enable = 1'b1;

    // Pass-through in all bands
    passthru_all();
    exp_q.push_back({3{22'h001234}});
    lanzar(22'h001234);
    recoger("pass", 0);

    // Overrun and write lockout at E0+10
    exp_q.push_back({3{22'h000777}});
    lanzar(22'h000777);
    repeat (9) tick();
    uk = 22'h3FFFFF;
    uk_valid = 1'b1;
    coef_addr = '0;
    coef_data = '0;
    coef_we = 1'b1;
    tick();
    uk_valid = 1'b0;
    coef_we = 1'b0;
    recoger("ovr", 10);
    chk("ovr_flag", VW'(overrun), VW'(1));
    extra = 0;
    repeat (45) begin
      tick();
      if (yk_valid === 1'b1) extra++;
    end
    chk("ovr_single_pulse", VW'(extra), VW'(0));
    exp_q.push_back({3{22'h000055}});
    lanzar(22'h000055);
    recoger("lockout", 0);
    chk("ovr_sticky", VW'(overrun), VW'(1));

    // Recursion: y = x + 0.5*y1 on band 0
    do_reset();
    wr(0, 22'h004000);
    wr(3, 22'h002000);
    wr(5, 22'h004000);
    exp_q.push_back({22'h0, 22'h0, 22'h004000});
    lanzar(22'h004000);
    recoger("rec0", 0);
    exp_q.push_back({22'h0, 22'h0, 22'h002000});
    lanzar(22'h000000);
    recoger("rec1", 0);
    exp_q.push_back({22'h0, 22'h0, 22'h001000});
    lanzar(22'h000000);
    recoger("rec2", 0);
    exp_q.push_back({22'h0, 22'h0, 22'h000800});
    lanzar(22'h000000);
    recoger("rec3", 0);

    // Saturation: first sample lands exactly on the maximum, later ones clamp
    do_reset();
    wr(0, 22'h004000);
    wr(1, 22'h004000);
    wr(2, 22'h004000);
    wr(5, 22'h004000);
    exp_q.push_back({22'h0, 22'h0, 22'h1FFFFF});
    lanzar(22'h1FFFFF);
    recoger("sat1", 0);
    chk("sat_not_yet", VW'(sat), VW'(0));
    exp_q.push_back({22'h0, 22'h0, 22'h1FFFFF});
    lanzar(22'h1FFFFF);
    recoger("sat2", 0);
    exp_q.push_back({22'h0, 22'h0, 22'h1FFFFF});
    lanzar(22'h1FFFFF);
    recoger("sat3", 0);
    chk("sat_flag", VW'(sat), VW'(1));

    // Half-up rounding on band 1: -1.5 -> -1, +1.5 -> 2
    do_reset();
    wr(10, 22'h002000);
    wr(15, 22'h004000);
    exp_q.push_back({22'h0, 22'h3FFFFF, 22'h0});
    lanzar(22'h3FFFFD);
    recoger("rnd_neg", 0);
    exp_q.push_back({22'h0, 22'h000002, 22'h0});
    lanzar(22'h000003);
    recoger("rnd_pos", 0);
    chk("rnd_no_sat", VW'(sat), VW'(0));

    // Reset in the middle of a sample
    do_reset();
    passthru_all();
    exp_q.push_back({3{22'h000321}});
    lanzar(22'h000321);
    recoger("pre_abort", 0);
    lanzar(22'h000999);
    repeat (19) tick();
    reset = 1'b0;
    #1;
    chk("abort_yk", yk, '0);
    chk("abort_busy", VW'(busy), VW'(0));
    chk("abort_valid", VW'(yk_valid), VW'(0));
    chk("abort_sat", VW'(sat), VW'(0));
    chk("abort_ovr", VW'(overrun), VW'(0));
    tick();
    reset = 1'b1;
    extra = 0;
    repeat (45) begin
      tick();
      if (yk_valid === 1'b1) extra++;
    end
    chk("abort_no_valid", VW'(extra), VW'(0));
    passthru_all();
    exp_q.push_back({3{22'h000ABC}});
    lanzar(22'h000ABC);
    recoger("post_abort", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filtro_banco_mux.md
# filtro_banco_mux

Time-multiplexed, coefficient-programmable IIR filter bank: `Bands` parallel bands, each a cascade of `Stages` direct-form-I biquads, all computed on one shared multiply-accumulate datapath. It is the parametrised successor to the fixed three-band, two-stage-per-band crossover. It sits between the audio sample source and the per-band gain/mix stage. Coefficients are loaded at run time through a write port instead of being hard-wired.

## Interface
- `Width`, 22, sample and coefficient word width, signed
- `Presicion`, 14, fractional bits of samples and coefficients
- `Bands`, 3, number of parallel bands, 1..8
- `Stages`, 2, biquads cascaded per band, 1..4
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state to reset values
- `enable`  in  1  when 0 no new sample is accepted; a sample in flight completes
- `uk_valid`  in  1  input sample strobe
- `uk`  in  Width  input sample, signed Q(Width-Presicion-1).Presicion
- `busy`  out  1  high from accept until yk_valid inclusive
- `yk`  out  Bands*Width  band outputs; band b in bits [b*Width +: Width]
- `yk_valid`  out  1  one-cycle pulse, yk updated
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  ceil(log2(Bands*Stages*5))  address = (band*Stages+stage)*5+tap
- `coef_data`  in  Width  coefficient, signed, same Q format as uk
- `sat`  out  1  sticky: any biquad result saturated
- `overrun`  out  1  sticky: uk_valid dropped while busy

## Operation
- Biquad per stage: y = b0·x + b1·x1 + b2·x2 + a1·y1 + a2·y2. The a-coefficients are stored pre-negated, so the datapath only adds. Tap order is 0..4 = b0, b1, b2, a1, a2.
- Stage 0 input is uk. Stage s>0 input is the stage s-1 result of the same band. yk of a band is its last-stage result.
- Each biquad keeps its own x1, x2, y1, y2, for Bands*Stages*4 state words in total.
- Arithmetic:
  - Each product is 2·Width bits.
  - The accumulator is 2·Width+3 bits and is cleared at tap 0.
  - The result is (acc + 2^(Presicion-1)) >>> Presicion, i.e. rounded half-up, then saturated to [-2^(Width-1), 2^(Width-1)-1].
  - Saturation sets `sat`.
- FSM:
  - IDLE: if `uk_valid & enable`, latch uk, set busy, and go to MAC. Set band=stage=tap=0.
  - MAC: one tap per cycle. After tap 4, go to STORE.
  - STORE: round and saturate. Shift the state (x2←x1, x1←x, y2←y1, y1←y). Forward y as the next stage input. Advance stage, then band. Return to MAC, or go to DONE after the last biquad.
  - DONE: register all band outputs to yk, pulse yk_valid, clear busy, and return to IDLE.
- Coefficients:
  - RAM of Bands*Stages*5 words, reset to 0.
  - A write is accepted only when busy=0.
  - Writes while busy, or to an out-of-range address, are ignored.
- A `uk_valid` arriving while busy (including the DONE cycle) is dropped and sets `overrun`.
- `sat` and `overrun` clear only on reset.

## Timing
- Reset values:
  - yk=0, yk_valid=0, busy=0, sat=0, overrun=0
  - all biquad state = 0, all coefficients = 0, FSM = IDLE
- Accepting edge E0. busy is high starting the cycle after E0.
- Per biquad: 6 cycles (5 MAC + 1 STORE).
- yk_valid is high for exactly the one cycle following edge E0 + Bands·Stages·6 + 1. With the defaults this is E0+37.
- busy falls together with yk_valid. A new sample can be accepted on the first edge after yk_valid.
- Maximum sample rate is f_clock / (Bands·Stages·6 + 2).
- When `enable` falls mid-sample, the sample still completes normally.
- Reset asserted mid-operation aborts immediately to reset values. No yk_valid pulse is produced.

## Structure
- Package `filtro_pkg`:
  - FSM state encoding (IDLE, MAC, STORE, DONE)
  - tap index constants B0..A2
  - function `redondea_satura` (round plus saturate, returning a saturation flag)
  - address-width helper function
- Sub-module `banco_coef`: coefficient RAM with write port and one combinational read port, addressed by the FSM counters.
- Top level holds the FSM, the MAC, and the state register file.

## Test plan
- Reset: after reset is released, yk=0, busy=0, sat=0, overrun=0. A sample with all coefficients at 0 yields yk=0 at E0+37.
- Pass-through: load b0=22'h4000 and all other taps 0 in every biquad. Apply uk=22'h001234. All three bands give 22'h001234, yk_valid at E0+37.
- Recursion:
  - Band 0, stage 0: b0=22'h4000, a1=22'h2000.
  - Band 0, stage 1: pass-through.
  - Apply an impulse 22'h4000 followed by zeros.
  - Band 0 outputs 22'h4000, 22'h2000, 22'h1000, 22'h0800.
- Saturation: b0=b1=b2=22'h4000 on stage 0, with stage 1 pass-through. Apply uk=22'h1FFFFF for three samples. Output is 22'h1FFFFF on samples 2–3, and sat=1.
- Overrun and write lockout:
  - Pulse uk_valid at E0+10: dropped, overrun=1, exactly one yk_valid.
  - Write coef_we at E0+10: ignored. A subsequent readback-by-behaviour is unchanged.
- Reset mid-sample: assert reset at E0+20. All outputs return to 0, and no yk_valid appears. A following sample processes normally.
